// File: rtl/alu_sched_pkg.sv
`default_nettype none
// ============================================================================
// Package : alu_sched_pkg
// Shared entry type, ALU function codes and CDB wakeup helper for alu_rs_sched.
// Rev     : 1.0
// ============================================================================
package alu_sched_pkg;

  localparam int OPE_W    = 32;
  localparam int FUNC_W   = 17;
  localparam int TAG_BITS = 5;

  localparam logic [FUNC_W-1:0] FN_ADD = FUNC_W'(1);
  localparam logic [FUNC_W-1:0] FN_SUB = FUNC_W'(2);
  localparam logic [FUNC_W-1:0] FN_AND = FUNC_W'(3);
  localparam logic [FUNC_W-1:0] FN_OR  = FUNC_W'(4);

  typedef struct packed {
    logic                valid;
    logic [FUNC_W-1:0]   func;
    logic [TAG_BITS-1:0] tag;
    logic                src1_rdy;
    logic [TAG_BITS-1:0] src1_tag;
    logic [OPE_W-1:0]    src1_val;
    logic                src2_rdy;
    logic [TAG_BITS-1:0] src2_tag;
    logic [OPE_W-1:0]    src2_val;
  } rs_entry_t;

  // Capture a CDB broadcast into any source still waiting on that tag.
  function automatic rs_entry_t wake(input rs_entry_t e, input logic cdb_valid,
                                     input logic [TAG_BITS-1:0] cdb_tag,
                                     input logic [OPE_W-1:0] cdb_value);
    rs_entry_t r;
    r = e;
    if (cdb_valid && !r.src1_rdy && (r.src1_tag == cdb_tag)) begin
      r.src1_rdy = 1'b1;
      r.src1_val = cdb_value;
    end
    if (cdb_valid && !r.src2_rdy && (r.src2_tag == cdb_tag)) begin
      r.src2_rdy = 1'b1;
      r.src2_val = cdb_value;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_rs_sched_if.sv
`default_nettype none
// ============================================================================
// Interface : alu_rs_sched_if
// Dispatch, CDB, ALU-drive and writeback signals of the ALU scheduler.
// Rev       : 1.0
// ============================================================================
interface alu_rs_sched_if #(
  parameter int OPE   = 32,
  parameter int FUNC  = 17,
  parameter int TAG_W = 5
);
  logic             disp_valid;
  logic             disp_ready;
  logic [FUNC-1:0]  disp_func;
  logic [TAG_W-1:0] disp_tag;
  logic             disp_src1_rdy;
  logic [TAG_W-1:0] disp_src1_tag;
  logic [OPE-1:0]   disp_src1_val;
  logic             disp_src2_rdy;
  logic [TAG_W-1:0] disp_src2_tag;
  logic [OPE-1:0]   disp_src2_val;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [OPE-1:0]   cdb_value;

  logic [FUNC-1:0]  op_func1;
  logic [FUNC-1:0]  op_func2;
  logic [OPE-1:0]   operand11;
  logic [OPE-1:0]   operand12;
  logic [OPE-1:0]   operand21;
  logic [OPE-1:0]   operand22;
  logic [OPE-1:0]   result1;
  logic [OPE-1:0]   result2;

  logic             wb1_valid;
  logic             wb1_ready;
  logic [TAG_W-1:0] wb1_tag;
  logic [OPE-1:0]   wb1_value;
  logic             wb2_valid;
  logic             wb2_ready;
  logic [TAG_W-1:0] wb2_tag;
  logic [OPE-1:0]   wb2_value;

  modport master (
    output disp_valid, disp_func, disp_tag,
    output disp_src1_rdy, disp_src1_tag, disp_src1_val,
    output disp_src2_rdy, disp_src2_tag, disp_src2_val,
    output cdb_valid, cdb_tag, cdb_value,
    output wb1_ready, wb2_ready,
    input  disp_ready,
    input  op_func1, op_func2, operand11, operand12, operand21, operand22,
    input  result1, result2,
    input  wb1_valid, wb1_tag, wb1_value, wb2_valid, wb2_tag, wb2_value
  );

  modport slave (
    input  disp_valid, disp_func, disp_tag,
    input  disp_src1_rdy, disp_src1_tag, disp_src1_val,
    input  disp_src2_rdy, disp_src2_tag, disp_src2_val,
    input  cdb_valid, cdb_tag, cdb_value,
    input  wb1_ready, wb2_ready,
    output disp_ready,
    output op_func1, op_func2, operand11, operand12, operand21, operand22,
    output result1, result2,
    output wb1_valid, wb1_tag, wb1_value, wb2_valid, wb2_tag, wb2_value
  );
endinterface
`default_nettype wire

// File: rtl/alu_rs_select.sv
`default_nettype none
// ============================================================================
// Module : alu_rs_select
// Oldest-first pick of up to two eligible entries onto the free ALU lanes.
// Rev    : 1.0
// ============================================================================
module alu_rs_select #(
  parameter int ENTRIES = 4
) (
  input  logic [ENTRIES-1:0] eligible,
  input  logic [1:0]         lane_free,
  output logic [ENTRIES-1:0] grant1,
  output logic [ENTRIES-1:0] grant2,
  output logic               issue1,
  output logic               issue2
);

  logic [ENTRIES-1:0] oldest;
  logic [ENTRIES-1:0] next_oldest;

  always_comb begin
    oldest      = '0;
    next_oldest = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (eligible[i]) begin
        if (oldest == '0) begin
          oldest[i] = 1'b1;
        end else if (next_oldest == '0) begin
          next_oldest[i] = 1'b1;
        end
      end
    end
  end

  // With lane 1 stalled the oldest candidate moves to lane 2 instead of waiting.
  always_comb begin
    grant1 = '0;
    grant2 = '0;
    if (lane_free[0]) begin
      grant1 = oldest;
      if (lane_free[1]) begin
        grant2 = next_oldest;
      end
    end else if (lane_free[1]) begin
      grant2 = oldest;
    end
    issue1 = |grant1;
    issue2 = |grant2;
  end

endmodule
`default_nettype wire

// File: rtl/alu_unit.sv
`default_nettype none
// ============================================================================
// Module : alu_unit
// Dual-lane combinational ALU; unknown function codes produce zero.
// Rev    : 1.0
// ============================================================================
module alu_unit
  import alu_sched_pkg::*;
#(
  parameter int OPE  = 32,
  parameter int FUNC = 17
) (
  input  logic [FUNC-1:0] op_func1,
  input  logic [FUNC-1:0] op_func2,
  input  logic [OPE-1:0]  operand11,
  input  logic [OPE-1:0]  operand12,
  input  logic [OPE-1:0]  operand21,
  input  logic [OPE-1:0]  operand22,
  output logic [OPE-1:0]  result1,
  output logic [OPE-1:0]  result2
);

  function automatic logic [OPE-1:0] calc(input logic [FUNC-1:0] f,
                                          input logic [OPE-1:0] a,
                                          input logic [OPE-1:0] b);
    logic [OPE-1:0] r;
    case (f)
      FN_ADD:  r = a + b;
      FN_SUB:  r = a - b;
      FN_AND:  r = a & b;
      FN_OR:   r = a | b;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign result1 = calc(op_func1, operand11, operand12);
  assign result2 = calc(op_func2, operand21, operand22);

endmodule
`default_nettype wire

// File: rtl/alu_rs_sched.sv
`default_nettype none
// ============================================================================
// Module : alu_rs_sched
// Two-lane collapsing reservation station feeding alu_unit with CDB wakeup.
// Rev    : 1.0
// ============================================================================
module alu_rs_sched
  import alu_sched_pkg::*;
#(
  parameter int OPE     = OPE_W,
  parameter int FUNC    = FUNC_W,
  parameter int ENTRIES = 4,
  parameter int TAG_W   = TAG_BITS
) (
  input logic           clk,
  input logic           rst,
  alu_rs_sched_if.slave bus
);

  localparam int CNT_W = $clog2(ENTRIES + 1);
  localparam int IDX_W = $clog2(ENTRIES);

  rs_entry_t          q  [ENTRIES];
  rs_entry_t          nq [ENTRIES];
  rs_entry_t          incoming;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic [CNT_W-1:0]   kept;
  logic [ENTRIES-1:0] eligible;
  logic [ENTRIES-1:0] grant1;
  logic [ENTRIES-1:0] grant2;
  logic               issue1;
  logic               issue2;
  logic               free1;
  logic               free2;
  logic               disp_ready;
  logic               accept;

  logic [FUNC-1:0]    func1;
  logic [FUNC-1:0]    func2;
  logic [OPE-1:0]     opa1;
  logic [OPE-1:0]     opb1;
  logic [OPE-1:0]     opa2;
  logic [OPE-1:0]     opb2;
  logic [TAG_W-1:0]   sel_tag1;
  logic [TAG_W-1:0]   sel_tag2;
  logic [OPE-1:0]     result1;
  logic [OPE-1:0]     result2;

  logic               wb1_valid;
  logic [TAG_W-1:0]   wb1_tag;
  logic [OPE-1:0]     wb1_value;
  logic               wb2_valid;
  logic [TAG_W-1:0]   wb2_tag;
  logic [OPE-1:0]     wb2_value;

  assign disp_ready = (count < CNT_W'(ENTRIES));
  assign accept     = bus.disp_valid && disp_ready;
  assign free1      = !wb1_valid || bus.wb1_ready;
  assign free2      = !wb2_valid || bus.wb2_ready;

  // Eligibility uses registered readiness only, so a CDB hit issues a cycle later.
  for (genvar i = 0; i < ENTRIES; i++) begin : g_elig
    assign eligible[i] = q[i].valid && q[i].src1_rdy && q[i].src2_rdy;
  end

  alu_rs_select #(.ENTRIES(ENTRIES)) u_select (
    .eligible  (eligible),
    .lane_free ({free2, free1}),
    .grant1    (grant1),
    .grant2    (grant2),
    .issue1    (issue1),
    .issue2    (issue2)
  );

  always_comb begin
    func1    = '0;
    func2    = '0;
    opa1     = '0;
    opb1     = '0;
    opa2     = '0;
    opb2     = '0;
    sel_tag1 = '0;
    sel_tag2 = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (grant1[i]) begin
        func1    = q[i].func;
        opa1     = q[i].src1_val;
        opb1     = q[i].src2_val;
        sel_tag1 = q[i].tag;
      end
      if (grant2[i]) begin
        func2    = q[i].func;
        opa2     = q[i].src1_val;
        opb2     = q[i].src2_val;
        sel_tag2 = q[i].tag;
      end
    end
  end

  alu_unit #(.OPE(OPE), .FUNC(FUNC)) u_alu (
    .op_func1  (func1),
    .op_func2  (func2),
    .operand11 (opa1),
    .operand12 (opb1),
    .operand21 (opa2),
    .operand22 (opb2),
    .result1   (result1),
    .result2   (result2)
  );

  always_comb begin
    incoming = '{valid:    1'b1,
                 func:     bus.disp_func,
                 tag:      bus.disp_tag,
                 src1_rdy: bus.disp_src1_rdy,
                 src1_tag: bus.disp_src1_tag,
                 src1_val: bus.disp_src1_val,
                 src2_rdy: bus.disp_src2_rdy,
                 src2_tag: bus.disp_src2_tag,
                 src2_val: bus.disp_src2_val};
  end

  // Survivors are compacted toward entry 0 in age order; the new op lands after them.
  always_comb begin
    kept = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      nq[i] = '0;
    end
    for (int i = 0; i < ENTRIES; i++) begin
      if (q[i].valid && !(grant1[i] || grant2[i])) begin
        nq[kept[IDX_W-1:0]] = wake(q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        kept = kept + CNT_W'(1);
      end
    end
    if (accept) begin
      nq[kept[IDX_W-1:0]] = wake(incoming, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
    end
    count_next = kept + CNT_W'(accept);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        q[i] <= '0;
      end
    end else begin
      count <= count_next;
      for (int i = 0; i < ENTRIES; i++) begin
        q[i] <= nq[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb1_valid <= 1'b0;
      wb1_tag   <= '0;
      wb1_value <= '0;
      wb2_valid <= 1'b0;
      wb2_tag   <= '0;
      wb2_value <= '0;
    end else begin
      if (issue1) begin
        wb1_valid <= 1'b1;
        wb1_tag   <= sel_tag1;
        wb1_value <= result1;
      end else if (free1) begin
        wb1_valid <= 1'b0;
      end
      if (issue2) begin
        wb2_valid <= 1'b1;
        wb2_tag   <= sel_tag2;
        wb2_value <= result2;
      end else if (free2) begin
        wb2_valid <= 1'b0;
      end
    end
  end

  assign bus.disp_ready = disp_ready;
  assign bus.op_func1   = func1;
  assign bus.op_func2   = func2;
  assign bus.operand11  = opa1;
  assign bus.operand12  = opb1;
  assign bus.operand21  = opa2;
  assign bus.operand22  = opb2;
  assign bus.result1    = result1;
  assign bus.result2    = result2;
  assign bus.wb1_valid  = wb1_valid;
  assign bus.wb1_tag    = wb1_tag;
  assign bus.wb1_value  = wb1_value;
  assign bus.wb2_valid  = wb2_valid;
  assign bus.wb2_tag    = wb2_tag;
  assign bus.wb2_value  = wb2_value;

endmodule
`default_nettype wire

// File: tb/tb_alu_rs_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_rs_sched
// Directed and random stimulus against a queue-based scheduler reference model.
// Rev    : 1.0
// ============================================================================
module tb_alu_rs_sched;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_rs_sched_if #(.OPE(32), .FUNC(17), .TAG_W(5)) bus ();

  alu_rs_sched #(.OPE(32), .FUNC(17), .ENTRIES(4), .TAG_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [16:0] func;
    logic [4:0]  tag;
    logic        r1;
    logic [4:0]  t1;
    logic [31:0] v1;
    logic        r2;
    logic [4:0]  t2;
    logic [31:0] v2;
  } uop_t;

  uop_t        mq[$];
  logic        mv[2];
  logic [4:0]  mt[2];
  logic [31:0] mval[2];

  uop_t        d;
  logic        d_valid;
  logic        c_valid;
  logic [4:0]  c_tag;
  logic [31:0] c_val;
  logic        rdy[2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [16:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    case (f)
      17'd1:   return a + b;
      17'd2:   return a - b;
      17'd3:   return a & b;
      17'd4:   return a | b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic uop_t cdb_apply(input uop_t u, input logic cv, input logic [4:0] ct,
                                     input logic [31:0] cval);
    if (cv && !u.r1 && u.t1 == ct) begin u.r1 = 1'b1; u.v1 = cval; end
    if (cv && !u.r2 && u.t2 == ct) begin u.r2 = 1'b1; u.v2 = cval; end
    return u;
  endfunction

  function automatic uop_t mk(input int f, input int tag, input logic r1, input int t1,
                              input logic [31:0] v1, input logic r2, input int t2,
                              input logic [31:0] v2);
    uop_t u;
    u.func = 17'(f); u.tag = 5'(tag);
    u.r1 = r1; u.t1 = 5'(t1); u.v1 = v1;
    u.r2 = r2; u.t2 = 5'(t2); u.v2 = v2;
    return u;
  endfunction

  task automatic set_idle();
    d_valid = 1'b0;
    d       = mk(0, 0, 1'b0, 0, 32'd0, 1'b0, 0, 32'd0);
    c_valid = 1'b0;
    c_tag   = 5'd0;
    c_val   = 32'd0;
    rdy[0]  = 1'b1;
    rdy[1]  = 1'b1;
  endtask

  task automatic apply_inputs();
    bus.disp_valid    = d_valid;
    bus.disp_func     = d.func;
    bus.disp_tag      = d.tag;
    bus.disp_src1_rdy = d.r1;
    bus.disp_src1_tag = d.t1;
    bus.disp_src1_val = d.v1;
    bus.disp_src2_rdy = d.r2;
    bus.disp_src2_tag = d.t2;
    bus.disp_src2_val = d.v2;
    bus.cdb_valid     = c_valid;
    bus.cdb_tag       = c_tag;
    bus.cdb_value     = c_val;
    bus.wb1_ready     = rdy[0];
    bus.wb2_ready     = rdy[1];
  endtask

  task automatic check_wb();
    check_val("wb1_valid", bus.wb1_valid, mv[0]);
    check_val("wb1_tag",   bus.wb1_tag,   mt[0]);
    check_val("wb1_value", bus.wb1_value, mval[0]);
    check_val("wb2_valid", bus.wb2_valid, mv[1]);
    check_val("wb2_tag",   bus.wb2_tag,   mt[1]);
    check_val("wb2_value", bus.wb2_value, mval[1]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    apply_inputs();
    #2 rst = 1'b1;
    #1;
    mq.delete();
    for (int n = 0; n < 2; n++) begin mv[n] = 1'b0; mt[n] = 5'd0; mval[n] = 32'd0; end
    check_wb();
    check_val("rst_disp_ready", bus.disp_ready, 1);
    check_val("rst_op_func1", bus.op_func1, 0);
    check_val("rst_op_func2", bus.op_func2, 0);
    check_val("rst_operands", {bus.operand11, bus.operand22}, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: apply stimulus, check issue outputs, advance the model, check writeback.
  task automatic step();
    int   elig[$];
    int   lanes[$];
    int   pick[2];
    uop_t s[2];
    uop_t rest[$];
    logic fr[2];
    logic acc;
    @(negedge clk);
    apply_inputs();
    #1;
    for (int n = 0; n < 2; n++) fr[n] = !mv[n] || rdy[n];
    foreach (mq[i]) if (mq[i].r1 && mq[i].r2) elig.push_back(i);
    for (int n = 0; n < 2; n++) if (fr[n]) lanes.push_back(n);
    pick[0] = -1;
    pick[1] = -1;
    for (int j = 0; j < elig.size() && j < lanes.size(); j++) pick[lanes[j]] = elig[j];
    for (int n = 0; n < 2; n++) begin
      if (pick[n] >= 0) s[n] = mq[pick[n]];
      else              s[n] = mk(0, 0, 1'b0, 0, 32'd0, 1'b0, 0, 32'd0);
    end
    check_val("disp_ready", bus.disp_ready, mq.size() < 4);
    check_val("op_func1",  bus.op_func1,  s[0].func);
    check_val("operand11", bus.operand11, s[0].v1);
    check_val("operand12", bus.operand12, s[0].v2);
    check_val("op_func2",  bus.op_func2,  s[1].func);
    check_val("operand21", bus.operand21, s[1].v1);
    check_val("operand22", bus.operand22, s[1].v2);

    acc = d_valid && (mq.size() < 4);
    for (int n = 0; n < 2; n++) begin
      if (pick[n] >= 0) begin
        mv[n] = 1'b1; mt[n] = s[n].tag; mval[n] = alu_ref(s[n].func, s[n].v1, s[n].v2);
      end else if (fr[n]) begin
        mv[n] = 1'b0;
      end
    end
    foreach (mq[i]) if (i != pick[0] && i != pick[1]) rest.push_back(cdb_apply(mq[i], c_valid, c_tag, c_val));
    if (acc) rest.push_back(cdb_apply(d, c_valid, c_tag, c_val));
    mq = rest;

    @(posedge clk);
    #1;
    check_wb();
    check_val("disp_ready_next", bus.disp_ready, mq.size() < 4);
  endtask

  initial begin
    set_idle();
    do_reset();

    // Single ADD: result appears on lane 1 one edge after the accepting edge.
    d_valid = 1'b1; d = mk(1, 3, 1'b1, 0, 32'd5, 1'b1, 0, 32'd7);
    step();
    set_idle();
    step();
    check_val("add_wb1_valid", bus.wb1_valid, 1);
    check_val("add_wb1_tag",   bus.wb1_tag,   3);
    check_val("add_wb1_value", bus.wb1_value, 12);
    check_val("add_wb2_idle",  bus.wb2_valid, 0);

    // Dual issue: stall both lanes so SUB and OR leave together.
    set_idle(); step();
    rdy[0] = 1'b0; rdy[1] = 1'b0;
    d_valid = 1'b1; d = mk(1, 10, 1'b1, 0, 32'd1, 1'b1, 0, 32'd1); step();
    d = mk(1, 11, 1'b1, 0, 32'd2, 1'b1, 0, 32'd2); step();
    d = mk(2, 1, 1'b1, 0, 32'd9, 1'b1, 0, 32'd4); step();
    d = mk(4, 2, 1'b1, 0, 32'hF0, 1'b1, 0, 32'h0F); step();
    set_idle(); step();
    check_val("dual_wb1_tag",   bus.wb1_tag,   1);
    check_val("dual_wb1_value", bus.wb1_value, 5);
    check_val("dual_wb2_tag",   bus.wb2_tag,   2);
    check_val("dual_wb2_value", bus.wb2_value, 32'hFF);
    check_val("dual_both_valid", {bus.wb1_valid, bus.wb2_valid}, 2'b11);

    // Wakeup through the CDB.
    set_idle(); step();
    d_valid = 1'b1; d = mk(3, 4, 1'b1, 0, 32'h0A, 1'b0, 9, 32'd0); step();
    set_idle(); step();
    c_valid = 1'b1; c_tag = 5'd9; c_val = 32'h0C; step();
    set_idle(); step();
    check_val("wake_wb1_tag",   bus.wb1_tag,   4);
    check_val("wake_wb1_value", bus.wb1_value, 8);

    // Dispatch bypass: CDB hit in the dispatch cycle.
    d_valid = 1'b1; d = mk(1, 5, 1'b0, 6, 32'd0, 1'b1, 0, 32'd1);
    c_valid = 1'b1; c_tag = 5'd6; c_val = 32'h11; step();
    set_idle(); step();
    check_val("byp_wb1_tag",   bus.wb1_tag,   5);
    check_val("byp_wb1_value", bus.wb1_value, 32'h12);

    // Backpressure: two issue into stalled lanes, four fill the station.
    set_idle(); step();
    rdy[0] = 1'b0; rdy[1] = 1'b0; d_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = mk(1, 20 + i, 1'b1, 0, 32'(i + 1), 1'b1, 0, 32'(i + 1));
      step();
    end
    check_val("bp_full_disp_ready", bus.disp_ready, 0);
    d_valid = 1'b0; rdy[0] = 1'b1;
    step();
    check_val("bp_wb1_tag",   bus.wb1_tag,   22);
    check_val("bp_wb1_value", bus.wb1_value, 6);
    check_val("bp_wb2_tag",   bus.wb2_tag,   21);
    check_val("bp_wb2_value", bus.wb2_value, 4);
    check_val("bp_wb2_valid", bus.wb2_valid, 1);

    // Asynchronous reset with pending entries and a held result.
    do_reset();

    for (int cyc = 0; cyc < 1500; cyc++) begin
      d_valid = ($urandom_range(0, 2) != 0);
      d = mk($urandom_range(0, 5), $urandom_range(0, 31),
             ($urandom_range(0, 2) != 0), $urandom_range(0, 7), $urandom,
             ($urandom_range(0, 2) != 0), $urandom_range(0, 7), $urandom);
      c_valid = ($urandom_range(0, 1) != 0);
      c_tag   = 5'($urandom_range(0, 7));
      c_val   = $urandom;
      rdy[0]  = ($urandom_range(0, 3) != 0);
      rdy[1]  = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
